// File: rtl/seg7_pkg.sv
// Shared constants, converter state encoding and segment lookup for the
// multiplexed seven-segment display.
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam logic MODE_HEX = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } bcd_state_t;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, with a sticky
// flag for any carry that falls off the top BCD digit.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   bcd_state_t          state_r;
   logic [DATA_W-1:0]   shift_r;
   logic [4*DIGITS-1:0] bcd_r;
   logic [4*DIGITS-1:0] adj_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                ovf_r;
   logic                busy_r;
   logic                done_r;

   // Add-3 correction of every BCD digit ahead of the next shift
   always_comb begin
      adj_s = bcd_r;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_r[4*i +: 4] > 4'd4) begin
            adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = bcd_r[4*i +: 4];
         end
      end
   end

   // Converter FSM; a bit leaving the top digit means value >= 10^DIGITS
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         shift_r <= '0;
         bcd_r   <= '0;
         cnt_r   <= '0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  shift_r <= bin;
                  bcd_r   <= '0;
                  cnt_r   <= '0;
                  ovf_r   <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_r   <= {adj_s[4*DIGITS-2:0], shift_r[DATA_W-1]};
               shift_r <= {shift_r[DATA_W-2:0], 1'b0};
               ovf_r   <= ovf_r | adj_s[4*DIGITS-1];
               cnt_r   <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(DATA_W - 1)) begin
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign bcd  = bcd_r;
   assign ovf  = ovf_r;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver for a debug value: hex or decimal display,
// leading-zero blanking, per-digit decimal points and overflow dashes.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 16,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value,
   input  logic              mode,
   input  logic              blank_lz,
   input  logic [DIGITS-1:0] dp_mask,
   input  logic              load,
   output logic              busy,
   output logic [7:0]        segments,
   output logic [DIGITS-1:0] an
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);

   logic [PRE_W-1:0]           presc_r;
   logic [IDX_W-1:0]           idx_r;
   logic [4*DIGITS-1:0]        disp_r;
   logic                       ovf_r;
   logic [DIGITS-1:0]          an_r;
   logic [7:0]                 seg_r;
   logic [4*DIGITS+DATA_W-1:0] wide_s;
   logic                       hex_ovf_s;
   logic                       accept_s;
   logic                       start_s;
   logic                       eng_busy_s;
   logic                       eng_done_s;
   logic [4*DIGITS-1:0]        eng_bcd_s;
   logic                       eng_ovf_s;
   logic [DIGITS-1:0]          blank_s;
   logic [DIGITS-1:0]          onehot_s;
   logic [3:0]                 cur_nib_s;
   logic [7:0]                 cur_seg_s;

   // Zero-extended copy so any bit above the displayable nibbles is an overflow
   assign wide_s    = {{(4*DIGITS){1'b0}}, value};
   assign hex_ovf_s = |wide_s[4*DIGITS+DATA_W-1:4*DIGITS];
   assign accept_s  = load & ~eng_busy_s;
   assign start_s   = accept_s & (mode == MODE_DEC);

   bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start_s),
      .bin   (value),
      .busy  (eng_busy_s),
      .done  (eng_done_s),
      .bcd   (eng_bcd_s),
      .ovf   (eng_ovf_s)
   );

   // Display register: immediate for hex, atomic commit at end of decimal conversion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_r <= '0;
         ovf_r  <= 1'b0;
      end else if (eng_done_s) begin
         disp_r <= eng_bcd_s;
         ovf_r  <= eng_ovf_s;
      end else if (accept_s && (mode == MODE_HEX)) begin
         disp_r <= wide_s[4*DIGITS-1:0];
         ovf_r  <= hex_ovf_s;
      end
   end

   // Refresh prescaler and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= '0;
         idx_r   <= '0;
      end else if (presc_r == PRE_W'(REFRESH_DIV - 1)) begin
         presc_r <= '0;
         if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         presc_r <= presc_r + PRE_W'(1);
      end
   end

   // Blanking mask, anode one-hot and segment pattern for the current digit
   always_comb begin
      logic zero_above_s;
      zero_above_s = 1'b1;
      blank_s      = '0;
      onehot_s     = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above_s = zero_above_s & (disp_r[4*i +: 4] == 4'h0);
         blank_s[i]   = blank_lz & zero_above_s & (i != 0);
         onehot_s[i]  = (idx_r == IDX_W'(i));
      end
      cur_nib_s = disp_r[4*int'(idx_r) +: 4];
      if (ovf_r) begin
         cur_seg_s = {~dp_mask[idx_r], SEG_DASH[6:0]};
      end else if (blank_s[idx_r]) begin
         cur_seg_s = {~dp_mask[idx_r], SEG_BLANK[6:0]};
      end else begin
         cur_seg_s = {~dp_mask[idx_r], hex_to_seg(cur_nib_s)};
      end
   end

   // Registered pin drivers, dark while in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r  <= '1;
         seg_r <= SEG_BLANK;
      end else begin
         an_r  <= ~onehot_s;
         seg_r <= cur_seg_s;
      end
   end

   assign an       = an_r;
   assign segments = seg_r;
   assign busy     = eng_busy_s;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: a 16-bit instance for most scenarios
// and a 20-bit instance for hex overflow.
module tb_seg7_scan_display;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [19:0] value20;
   logic        mode;
   logic        blank_lz;
   logic [3:0]  dp_mask;
   logic        load;
   logic        load20;
   logic        busy;
   logic        busy20;
   logic [7:0]  segments;
   logic [7:0]  segments20;
   logic [3:0]  an;
   logic [3:0]  an20;

   int checks;
   int errors;

   seg7_scan_display #(.DIGITS(4), .DATA_W(16), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .value(value), .mode(mode), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .load(load), .busy(busy), .segments(segments), .an(an)
   );

   seg7_scan_display #(.DIGITS(4), .DATA_W(20), .REFRESH_DIV(4)) dut20 (
      .clk(clk), .rst(rst), .value(value20), .mode(mode), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .load(load20), .busy(busy20), .segments(segments20), .an(an20)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic get_seg(input int d, input bit wide, output logic [7:0] s, output bit ok);
      logic [3:0] target;
      target = ~(4'b0001 << d);
      ok = 1'b0;
      s  = 8'h00;
      for (int n = 0; n < 40 && !ok; n++) begin
         if ((wide ? an20 : an) === target) begin
            ok = 1'b1;
            s  = wide ? segments20 : segments;
         end else begin
            tick();
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         if (busy === 1'b0) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic m);
      value = v;
      mode  = m;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want %h", an, 4'hF); end
      checks++;
      if (segments !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want %h", segments, 8'hFF); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want %b", busy, 1'b0); end
      #2 rst = 1'b0;
      tick();
      checks++;
      if (an !== 4'hE) begin errors++; $display("FAIL first_an got %h want %h", an, 4'hE); end
      checks++;
      if (segments !== 8'hC0) begin errors++; $display("FAIL first_seg got %h want %h", segments, 8'hC0); end
   endtask

   task automatic test_hex_scan();
      logic [7:0] exp_v [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
      logic [3:0] prev;
      logic [3:0] exp_an;
      bit found;
      bit saw_busy;
      pulse_load(16'h1A3F, 1'b0);
      saw_busy = busy;
      prev  = an;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         saw_busy = saw_busy | busy;
         if (an === 4'hE && prev !== 4'hE) found = 1'b1;
         prev = an;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL hex_sync got %b want %b", found, 1'b1); end
      for (int j = 0; j < 16; j++) begin
         exp_an = ~(4'b0001 << (j / 4));
         checks++;
         if (an !== exp_an) begin errors++; $display("FAIL hex_an[%0d] got %h want %h", j, an, exp_an); end
         checks++;
         if (segments !== exp_v[j/4]) begin errors++; $display("FAIL hex_seg[%0d] got %h want %h", j, segments, exp_v[j/4]); end
         saw_busy = saw_busy | busy;
         tick();
      end
      checks++;
      if (saw_busy !== 1'b0) begin errors++; $display("FAIL hex_busy got %b want %b", saw_busy, 1'b0); end
   endtask

   task automatic test_dec_convert();
      logic [7:0] old_v [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
      logic [7:0] exp_v [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      logic [7:0] s;
      logic [3:0] t;
      bit ok;
      bit old_ok;
      int n;
      pulse_load(16'd1234, 1'b1);
      n = 0;
      old_ok = 1'b1;
      while (busy === 1'b1 && n < 40) begin
         n++;
         for (int d = 0; d < 4; d++) begin
            t = ~(4'b0001 << d);
            if (an === t && segments !== old_v[d]) old_ok = 1'b0;
         end
         tick();
      end
      checks++;
      if (n != 17) begin errors++; $display("FAIL dec_busy_len got %0d want %0d", n, 17); end
      checks++;
      if (old_ok !== 1'b1) begin errors++; $display("FAIL dec_old_held got %b want %b", old_ok, 1'b1); end
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b0, s, ok);
         checks++;
         if (!ok || s !== exp_v[d]) begin errors++; $display("FAIL dec_d%0d got %h want %h", d, s, exp_v[d]); end
      end
   endtask

   task automatic test_blank_dp();
      logic [7:0] exp_v [4] = '{8'hF8, 8'hFF, 8'h7F, 8'hFF};
      logic [7:0] s;
      bit ok;
      blank_lz = 1'b1;
      dp_mask  = 4'b0100;
      pulse_load(16'd7, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL blank_idle got %b want %b", ok, 1'b1); end
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b0, s, ok);
         checks++;
         if (!ok || s !== exp_v[d]) begin errors++; $display("FAIL blank_d%0d got %h want %h", d, s, exp_v[d]); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] ovf_v [4] = '{8'h3F, 8'hBF, 8'hBF, 8'hBF};
      logic [7:0] s;
      bit ok;
      blank_lz = 1'b1;
      dp_mask  = 4'b0000;
      pulse_load(16'd9999, 1'b1);
      wait_idle(ok);
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b0, s, ok);
         checks++;
         if (!ok || s !== 8'h90) begin errors++; $display("FAIL dec9999_d%0d got %h want %h", d, s, 8'h90); end
      end
      dp_mask = 4'b0001;
      pulse_load(16'd12345, 1'b1);
      wait_idle(ok);
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b0, s, ok);
         checks++;
         if (!ok || s !== ovf_v[d]) begin errors++; $display("FAIL decovf_d%0d got %h want %h", d, s, ovf_v[d]); end
      end
      dp_mask = 4'b0000;
      mode    = 1'b0;
      value20 = 20'h0FFFF;
      load20  = 1'b1;
      tick();
      load20  = 1'b0;
      checks++;
      if (busy20 !== 1'b0) begin errors++; $display("FAIL hex20_busy got %b want %b", busy20, 1'b0); end
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b1, s, ok);
         checks++;
         if (!ok || s !== 8'h8E) begin errors++; $display("FAIL hex20max_d%0d got %h want %h", d, s, 8'h8E); end
      end
      value20 = 20'h10000;
      load20  = 1'b1;
      tick();
      load20  = 1'b0;
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b1, s, ok);
         checks++;
         if (!ok || s !== 8'hBF) begin errors++; $display("FAIL hex20ovf_d%0d got %h want %h", d, s, 8'hBF); end
      end
   endtask

   task automatic test_ignored_load();
      logic [7:0] exp_v [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
      logic [7:0] s;
      bit ok;
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;
      pulse_load(16'd4321, 1'b1);
      repeat (4) tick();
      pulse_load(16'd9876, 1'b1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want %b", busy, 1'b1); end
      wait_idle(ok);
      tick();
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b0, s, ok);
         checks++;
         if (!ok || s !== exp_v[d]) begin errors++; $display("FAIL ign_d%0d got %h want %h", d, s, exp_v[d]); end
      end
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ign_requeue got %b want %b", busy, 1'b0); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] s;
      bit ok;
      pulse_load(16'd5555, 1'b1);
      repeat (7) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want %b", busy, 1'b1); end
      rst = 1'b1;
      #2;
      checks++;
      if (an !== 4'hF) begin errors++; $display("FAIL mid_an got %h want %h", an, 4'hF); end
      checks++;
      if (segments !== 8'hFF) begin errors++; $display("FAIL mid_seg got %h want %h", segments, 8'hFF); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want %b", busy, 1'b0); end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (an !== 4'hE) begin errors++; $display("FAIL mid_first_an got %h want %h", an, 4'hE); end
      checks++;
      if (segments !== 8'hC0) begin errors++; $display("FAIL mid_first_seg got %h want %h", segments, 8'hC0); end
      repeat (25) tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_no_commit_busy got %b want %b", busy, 1'b0); end
      for (int d = 0; d < 4; d++) begin
         get_seg(d, 1'b0, s, ok);
         checks++;
         if (!ok || s !== 8'hC0) begin errors++; $display("FAIL mid_d%0d got %h want %h", d, s, 8'hC0); end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      value    = 16'h0000;
      value20  = 20'h00000;
      mode     = 1'b0;
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;
      load     = 1'b0;
      load20   = 1'b0;
      test_reset();
      test_hex_scan();
      test_dec_convert();
      test_blank_dp();
      test_overflow();
      test_ignored_load();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed seven-segment driver for the CPU's debug output, for example the value of register x5.
- Successor to the fixed 4-digit hex display: digit count, input width and refresh rate are parameters.
- Adds a sequential binary-to-decimal display mode, leading-zero blanking, per-digit decimal points and overflow indication.
- Sits between the core's debug value and the board's segment/anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
DATA_W, 16, width of value input (4..32)
REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
value  input  DATA_W  unsigned value to display
mode  input  1  0 = hexadecimal, 1 = unsigned decimal
blank_lz  input  1  1 = blank leading zero digits
dp_mask  input  DIGITS  decimal-point enables, bit i = digit i (digit 0 = rightmost)
load  input  1  one-cycle request to sample value/mode
busy  output  1  decimal conversion in progress
segments  output  8  active-low {dp,g,f,e,d,c,b,a}
an  output  DIGITS  active-low one-hot digit enable

Behaviour:
- Reset (asynchronous, active-high):
  - Values while rst is high: an = all 1s, segments = 8'hFF, busy = 0.
  - Internal state cleared: displayed digits = 0, digit index = 0, prescaler = 0, overflow flag = 0.
  - Reset mid-conversion aborts it; nothing is committed.
- Outputs are registered.
  - First edge after reset release: an = ~1 (digit 0 enabled).
  - segments = encoding of digit 0 of the display register.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count the index advances and wraps DIGITS-1 -> 0.
  - an/segments follow the index with one cycle latency.
  - Exactly one an bit is low at any time after reset.
- load handling: load is accepted only when busy = 0. A load while busy = 1 is ignored (no queue).
- Hex mode (load at edge t):
  - Display register gets nibbles value[4i+3:4i] at edge t+1. busy stays 0.
  - Overflow if DATA_W > 4*DIGITS and any bit above 4*DIGITS-1 is set.
- Decimal mode (load at edge t):
  - Sequential double-dabble, one bit per cycle.
  - busy = 1 for exactly DATA_W+1 cycles, starting at edge t+1.
  - All digits commit atomically at the edge where busy falls.
  - The old display keeps scanning until commit; there is no partial update.
  - Overflow if value > 10^DIGITS - 1.
- Overflow display: every digit shows '-' = 8'hBF. dp still follows dp_mask. Blanking is not applied.
- Leading-zero blanking: when blank_lz = 1, digits above the most significant nonzero digit show blank (8'hFF).
  - The dp bit is still driven from dp_mask, so a blanked digit with its dp enabled shows 8'h7F.
  - Digit 0 is never blanked.
  - mode, blank_lz and dp_mask are sampled live for blanking/dp, not latched by load.
- Encoding, active-low gfedcba:
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
  - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
  - dp lit clears bit 7.

Decomposition:
- Package seg7_pkg:
  - Segment code constants (SEG_BLANK = 8'hFF, SEG_DASH = 8'hBF).
  - Function hex_to_seg(4-bit) -> 7-bit.
  - Mode encodings (MODE_HEX = 0, MODE_DEC = 1).
- Sub-module bin2bcd_seq, the double-dabble engine:
  - Inputs: clk, rst, start, bin[DATA_W].
  - Outputs: busy, done pulse, bcd[4*DIGITS], ovf.
  - FSM IDLE -> SHIFT (DATA_W cycles) -> DONE (1 cycle) -> IDLE.

Test Plan:
1. Reset, then DIGITS=4, REFRESH_DIV=4, hex, load value=16'h1A3F -> an cycles E,D,B,7 every 4 cycles; segments 8E,B0,88,F9 respectively; busy never 1.
2. Decimal, DATA_W=16, load value=1234 -> busy high exactly 17 cycles, old digits shown until commit, then digits 4,3,2,1 (99,B0,A4,F9).
3. Decimal, blank_lz=1, value=7, dp_mask=4'b0100 -> digit0 F8, digit1 FF, digit2 7F, digit3 FF.
4. Decimal value=16'd12345 with DIGITS=4 -> all digits BF after commit; hex DATA_W=20, DIGITS=4, value=20'h10000 -> all BF.
5. Second load pulse 5 cycles into a decimal conversion -> ignored; result reflects first value only.
6. Assert rst mid-conversion (cycle 8) -> an=F, segments=FF, busy=0 immediately; after release, digit 0 shows C0 and the display register is 0.
